// File: rtl/conv1d_sram_responder.sv
// Single-port SRAM responder for the conv1d request/response interface.
// Byte-enabled writes, fixed-latency pipelined reads, range error flag and saturating access counters.

package conv1d_sram_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } sram_rsp_t;

endpackage

module conv1d_sram_responder
  import conv1d_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  sram_req_t   req_i,
  output sram_rsp_t   rsp_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned L  = RD_LATENCY;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "conv1d_sram_responder: RD_LATENCY must be 1..4");
  end
  if (NUM_WORDS < 16 || NUM_WORDS > 65536 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_words
    $fatal(1, "conv1d_sram_responder: NUM_WORDS must be a power of two in 16..65536");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $fatal(1, "conv1d_sram_responder: BASE_ADDR must be 4-byte aligned");
  end

  logic [31:0] r_mem [NUM_WORDS];

  logic [31:0]   w_word_off;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_rd;
  logic          w_wr;
  logic [31:0]   w_rd_data;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign w_word_off = (req_i.addr - BASE_ADDR) >> 2;
  assign w_in_range = (w_word_off < NUM_WORDS);
  assign w_idx      = w_word_off[AW-1:0];
  assign w_rd       = req_i.req & ~req_i.we;
  assign w_wr       = req_i.req &  req_i.we;
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : 32'h0000_0000;

  // NOTE: the memory array has no reset; its contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (w_wr && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_i.be[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  logic [L-1:0] r_pv;
  logic [L-1:0] r_pe;
  logic [31:0]  r_pd [L];

  logic [L-1:0] w_v_in;
  logic [L-1:0] w_e_in;
  logic [31:0]  w_d_in [L];

  assign w_d_in[0] = w_rd_data;

  if (L > 1) begin : g_shift
    assign w_v_in = {r_pv[L-2:0], w_rd};
    assign w_e_in = {r_pe[L-2:0], w_rd & ~w_in_range};
    for (genvar g = 1; g < L; g++) begin : g_data
      assign w_d_in[g] = r_pd[g-1];
    end
  end else begin : g_single
    assign w_v_in = w_rd;
    assign w_e_in = w_rd & ~w_in_range;
  end

  // The last data stage loads only on a valid response, so rdata holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int i = 0; i < L; i++) begin
        r_pd[i] <= '0;
      end
    end else begin
      r_pv <= w_v_in;
      r_pe <= w_e_in;
      for (int i = 0; i < L; i++) begin
        if ((i < L - 1) || w_v_in[i]) begin
          r_pd[i] <= w_d_in[i];
        end
      end
    end
  end

  logic        r_wr_err;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_err <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_wr_err <= w_wr & ~w_in_range;
      if (w_rd && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_wr && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign rsp_o.rdata = r_pd[L-1];
  assign rvalid_o    = r_pv[L-1];
  assign err_o       = (r_pv[L-1] & r_pe[L-1]) | r_wr_err;
  assign rd_cnt_o    = r_rd_cnt;
  assign wr_cnt_o    = r_wr_cnt;

endmodule

// File: doc/conv1d_sram_responder.md
Name: conv1d_sram_responder

Overview:
- Single-port SRAM responder: the memory-side end of the conv1d SRAM request/response interface.
- Accepts one `sram_req_t` per cycle and performs byte-enabled writes or fixed-latency reads.
- Returns read data as `sram_rsp_t`, with a valid strobe, an error flag and saturating access counters.
- Used as the accelerator's local scratch memory and as the responder model in the accelerator testbenches.

Parameters:
- NUM_WORDS, 1024, number of 32-bit words stored; power of two, 16..65536.
- RD_LATENCY, 1, cycles from read request to rvalid_o; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  70  conv1d_sram_pkg::sram_req_t: {req, we, be[3:0], addr[31:0], wdata[31:0]}.
- rsp_o  out  32  conv1d_sram_pkg::sram_rsp_t: {rdata[31:0]}.
- rvalid_o  out  1  rsp_o.rdata carries the response to a read issued RD_LATENCY cycles earlier.
- err_o  out  1  that read, or a write in the previous cycle, was out of range.
- rd_cnt_o  out  16  saturating count of accepted reads.
- wr_cnt_o  out  16  saturating count of accepted writes.

Behaviour:
- Always ready; no grant signal. Every cycle with req_i.req=1 is one accepted access.
- Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
- In range ⇔ addr >= BASE_ADDR and index < NUM_WORDS, computed on a 32-bit unsigned difference.
  - An addr below BASE_ADDR wraps to a huge index and is therefore out of range.
- Write (req=1, we=1, in range):
  - For each i with be[i]=1, byte i of the word ← wdata[8i+7:8i]; bytes with be[i]=0 are unchanged.
  - be=4'b0000 leaves the word unchanged but still counts as a write.
  - The write is visible to a read issued in the next cycle.
- Read (req=1, we=0):
  - The word is sampled at the request edge and pushed into a RD_LATENCY-deep valid/data/err pipeline.
  - be is ignored on reads.
  - rvalid_o=1 exactly RD_LATENCY cycles after the request cycle, for one cycle per read.
  - Back-to-back reads give back-to-back rvalid_o pulses in order (full throughput).
- Write to the same address while an earlier read is still in the pipeline: the read returns the old data, because it was sampled at its own request edge.
- Out-of-range read:
  - rdata returned = 32'h0000_0000.
  - err_o=1 in the same cycle as its rvalid_o.
- Out-of-range write:
  - Memory is unchanged.
  - err_o=1 for one cycle, the cycle after the request, with rvalid_o=0.
  - If this coincides with a read's err_o slot, err_o is the OR of both.
- rsp_o.rdata holds the last returned read data when rvalid_o=0; it does not return to 0 between reads.
- Counters:
  - rd_cnt_o and wr_cnt_o increment on accepted reads/writes, including out-of-range ones.
  - Both saturate at 16'hFFFF.
- req=0: no memory access, no counter change; pipeline shifts normally.
- Reset (asynchronous assert, synchronous release):
  - rvalid_o=0, err_o=0, rsp_o.rdata=0, rd_cnt_o=0, wr_cnt_o=0, all pipeline valid bits=0.
  - Memory array contents are NOT reset and are retained across reset.
  - Reset mid-operation drops all in-flight reads: no rvalid_o after deassert for reads issued before reset.
  - A request in the first cycle after rst_ni rises is accepted normally.
- Illegal parameters: RD_LATENCY outside 1..4, or NUM_WORDS not a power of two, fail elaboration (static assertion).

Test Plan:
1. Single write/read:
   - Stimulus: RD_LATENCY=1; write addr=0x10, be=4'hF, wdata=0xA5A5_1234; next cycle read 0x10.
   - Required: rvalid_o=1 one cycle after the read, rdata=0xA5A5_1234, err_o=0, rd_cnt_o=1, wr_cnt_o=1.
2. Byte enables:
   - Stimulus: write 0x20 with 0x1122_3344 (be=F), then write 0x20 with 0xFFFF_FFFF (be=4'b0101), then read 0x20.
   - Required: rdata=0x11FF_33FF.
3. Latency/throughput:
   - Stimulus: RD_LATENCY=3; preload words 0..3 with 0..3; reads of 0x0, 0x4, 0x8, 0xC on consecutive cycles.
   - Required: rvalid_o high for 4 consecutive cycles starting 3 cycles after the first read, rdata 0, 1, 2, 3 in order.
4. Out of range:
   - Stimulus: NUM_WORDS=1024, BASE_ADDR=0x1000; read 0x2000, then read 0x0FFC, then write 0x2000.
   - Required:
     - rdata=0 with err_o=1 on each of the two read responses.
     - err_o=1 the cycle after the write; memory unchanged.
     - rd_cnt_o=2, wr_cnt_o=1.
5. Read/write hazard:
   - Stimulus: RD_LATENCY=2; word 0x40 holds 0x1; read 0x40, then next cycle write 0x40 with 0x2, then read 0x40.
   - Required: first response 0x1, second response 0x2.
6. Reset mid-flight:
   - Stimulus: RD_LATENCY=4; issue a read, assert rst_ni low 2 cycles later for 1 cycle.
   - Required: outputs and counters go to 0 immediately; no rvalid_o ever appears for that read; previously written data still readable after reset.
